// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the four-approach signal controller and the lamps.
// Healthy light codes pass through with one cycle of registration. Any
// conflict, illegal code or sequencing violation latches a fault code and
// forces flashing red until fault_clr is given on a clean input cycle.
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int MAX_STABLE  = 64,
  parameter int RECOVER_CYC = 8,
  parameter int FLASH_HALF  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lightM1,
  input  logic [2:0] lightM2,
  input  logic [2:0] lightM3,
  input  logic [2:0] lightM4,
  input  logic       fault_clr,
  output logic [2:0] lampM1,
  output logic [2:0] lampM2,
  output logic [2:0] lampM3,
  output logic [2:0] lampM4,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int STW = $clog2(MAX_STABLE) + 1;
  localparam int RCW = $clog2(RECOVER_CYC + 1);
  localparam int FCW = $clog2(FLASH_HALF + 1);
  localparam logic [STW-1:0] STUCK_AT   = STW'(MAX_STABLE - 1);
  localparam logic [RCW-1:0] REC_LAST   = RCW'(RECOVER_CYC - 1);
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_HALF - 1);
  localparam logic [2:0]     MIN_Y      = 3'(MIN_YELLOW);

  typedef enum logic [1:0] {S_RECOVER, S_MONITOR, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [3:0][2:0] cur;
  logic [3:0][2:0] prev_q, prev_d;
  logic [3:0][2:0] lamp_q, lamp_d;
  logic [2:0]      yel_a_q, yel_a_d, yel_b_q, yel_b_d;
  logic [STW-1:0]  stable_q, stable_d;
  logic [RCW-1:0]  rec_q, rec_d;
  logic [FCW-1:0]  flash_q, flash_d;
  logic            phase_q, phase_d;
  logic            fault_q, fault_d;
  logic [2:0]      code_q, code_d;

  logic            illegal, conflict, mismatch, seq_bad, short_bad, same, stuck;
  logic [2:0]      code_lo, code_hi;

  // Legal per-lamp transitions: hold, RED->GREEN, GREEN->YELLOW, YELLOW->RED
  function automatic logic seq_ok(input logic [2:0] p, input logic [2:0] c);
    return (c == p) || (p == RED && c == GRN) || (p == GRN && c == YEL) ||
           (p == YEL && c == RED);
  endfunction

  // index 0 = M1 ... 3 = M4; even indices are axis A, odd are axis B
  assign cur      = {lightM4, lightM3, lightM2, lightM1};
  assign conflict = (cur[0] != RED || cur[2] != RED) && (cur[1] != RED || cur[3] != RED);
  assign mismatch = (cur[0] != cur[2]) || (cur[1] != cur[3]);
  assign same     = (cur == prev_q);
  assign stuck    = same && (stable_q >= STUCK_AT);

  // Per-lamp checks against the previous sample and the axis yellow counters
  always_comb begin
    illegal   = 1'b0;
    seq_bad   = 1'b0;
    short_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!(cur[i] == RED || cur[i] == YEL || cur[i] == GRN)) illegal = 1'b1;
      if (!seq_ok(prev_q[i], cur[i])) seq_bad = 1'b1;
      if (prev_q[i] == YEL && cur[i] != YEL &&
          (((i % 2) == 0) ? yel_a_q : yel_b_q) < MIN_Y) short_bad = 1'b1;
    end
    code_lo = illegal ? 3'd1 : conflict ? 3'd2 : mismatch ? 3'd3 : 3'd0;
    code_hi = seq_bad ? 3'd4 : short_bad ? 3'd5 : stuck ? 3'd6 : 3'd0;
  end

  // State transitions and lamp drive
  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q;
    fault_d = fault_q;
    code_d  = code_q;
    phase_d = phase_q;
    flash_d = flash_q;
    rec_d   = rec_q;
    unique case (state_q)
      S_RECOVER: begin
        lamp_d = {4{RED}};
        rec_d  = rec_q + 1'b1;
        if (code_lo != 3'd0) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = code_lo;
          phase_d = 1'b1;
          flash_d = '0;
        end else if (rec_q == REC_LAST) begin
          state_d = S_MONITOR;
        end
      end
      S_MONITOR: begin
        if (code_lo != 3'd0 || code_hi != 3'd0) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = (code_lo != 3'd0) ? code_lo : code_hi;
          lamp_d  = {4{RED}};
          phase_d = 1'b1;
          flash_d = '0;
        end else begin
          lamp_d = cur;
        end
      end
      S_FAULT: begin
        if (flash_q == FLASH_LAST) begin
          flash_d = '0;
          phase_d = ~phase_q;
        end else begin
          flash_d = flash_q + 1'b1;
        end
        lamp_d = phase_d ? {4{RED}} : '0;
        // a clear is only trusted once the controller output is sane again
        if (fault_clr && code_lo == 3'd0) begin
          state_d = S_RECOVER;
          fault_d = 1'b0;
          code_d  = 3'd0;
          lamp_d  = {4{RED}};
          rec_d   = '0;
        end
      end
      default: state_d = S_RECOVER;
    endcase
  end

  // History trackers: previous sample, yellow run lengths, unchanged-input run
  always_comb begin
    prev_d  = cur;
    yel_a_d = (cur[0] != YEL) ? 3'd0 : (yel_a_q == 3'd7) ? 3'd7 : yel_a_q + 3'd1;
    yel_b_d = (cur[1] != YEL) ? 3'd0 : (yel_b_q == 3'd7) ? 3'd7 : yel_b_q + 3'd1;
    if (!same || (state_q == S_RECOVER && state_d == S_MONITOR)) stable_d = '0;
    else if (stable_q >= STUCK_AT)                                  stable_d = stable_q;
    else                                                            stable_d = stable_q + 1'b1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RECOVER;
      rec_q    <= '0;
      lamp_q   <= {4{RED}};
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      phase_q  <= 1'b0;
      flash_q  <= '0;
      prev_q   <= {4{RED}};
      yel_a_q  <= 3'd0;
      yel_b_q  <= 3'd0;
      stable_q <= '0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      lamp_q   <= lamp_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      flash_q  <= flash_d;
      prev_q   <= prev_d;
      yel_a_q  <= yel_a_d;
      yel_b_q  <= yel_b_d;
      stable_q <= stable_d;
    end
  end

  assign lampM1     = lamp_q[0];
  assign lampM2     = lamp_q[1];
  assign lampM3     = lamp_q[2];
  assign lampM4     = lamp_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed table, hand sequences for the
// multi-cycle corners, then random controller traffic against a rule model.
module tb_traffic_conflict_monitor;
  localparam int MIN_YELLOW  = 3;
  localparam int MAX_STABLE  = 64;
  localparam int RECOVER_CYC = 8;
  localparam int FLASH_HALF  = 4;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [11:0] ALLR = {RED, RED, RED, RED};
  localparam logic [11:0] AGRN = {GRN, RED, GRN, RED};
  localparam logic [11:0] AYEL = {YEL, RED, YEL, RED};
  localparam logic [11:0] BGRN = {RED, GRN, RED, GRN};
  localparam logic [11:0] BYEL = {RED, YEL, RED, YEL};
  localparam logic [11:0] CONF = {GRN, GRN, GRN, RED};
  localparam logic [11:0] OFF  = 12'h000;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] l1, l2, l3, l4;
  logic fclr;
  logic [2:0] o1, o2, o3, o4;
  logic fault;
  logic [2:0] fault_code;
  wire  [11:0] lamps_w = {o1, o2, o3, o4};

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .MAX_STABLE(MAX_STABLE),
    .RECOVER_CYC(RECOVER_CYC), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .rst(rst),
    .lightM1(l1), .lightM2(l2), .lightM3(l3), .lightM4(l4),
    .fault_clr(fclr),
    .lampM1(o1), .lampM2(o2), .lampM3(o3), .lampM4(o4),
    .fault(fault), .fault_code(fault_code)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- rule model ----------------
  // mode: 0 all-red hold, 1 watching, 2 latched fault
  int m_mode, m_hold, m_ya, m_yb, m_same_run, m_fcnt, m_on, m_fault, m_code;
  int m_cur[4], m_prev[4], m_lamp[4];

  function automatic bit legal(input int x);
    return x == 4 || x == 2 || x == 1;
  endfunction

  function automatic bit move_ok(input int p, input int c);
    return c == p || (p == 4 && c == 1) || (p == 1 && c == 2) || (p == 2 && c == 4);
  endfunction

  // first broken rule in priority order; full=0 checks only the codes 1..3
  function automatic int rule_code(input bit full);
    bit unchanged;
    for (int i = 0; i < 4; i++) if (!legal(m_cur[i])) return 1;
    if ((m_cur[0] != 4 || m_cur[2] != 4) && (m_cur[1] != 4 || m_cur[3] != 4)) return 2;
    if (m_cur[0] != m_cur[2] || m_cur[1] != m_cur[3]) return 3;
    if (!full) return 0;
    for (int i = 0; i < 4; i++) if (!move_ok(m_prev[i], m_cur[i])) return 4;
    for (int i = 0; i < 4; i++)
      if (m_prev[i] == 2 && m_cur[i] != 2 && (((i % 2) == 0) ? m_ya : m_yb) < MIN_YELLOW) return 5;
    unchanged = 1'b1;
    for (int i = 0; i < 4; i++) if (m_cur[i] != m_prev[i]) unchanged = 1'b0;
    if (unchanged && m_same_run + 1 >= MAX_STABLE) return 6;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hold = 0; m_ya = 0; m_yb = 0; m_same_run = 0;
    m_fcnt = 0; m_on = 0; m_fault = 0; m_code = 0;
    for (int i = 0; i < 4; i++) begin m_prev[i] = 4; m_lamp[i] = 4; end
  endtask

  task automatic model_fault(input int c);
    m_mode = 2; m_fault = 1; m_code = c; m_on = 1; m_fcnt = 0;
    for (int i = 0; i < 4; i++) m_lamp[i] = 4;
  endtask

  task automatic model_step(input bit clr);
    int v, v_lo;
    bit unchanged, entered;
    v_lo = rule_code(1'b0);
    v = rule_code(m_mode == 1);
    unchanged = 1'b1;
    for (int i = 0; i < 4; i++) if (m_cur[i] != m_prev[i]) unchanged = 1'b0;
    entered = 1'b0;
    if (m_mode == 0) begin
      for (int i = 0; i < 4; i++) m_lamp[i] = 4;
      if (v != 0) model_fault(v);
      else begin
        m_hold++;
        if (m_hold == RECOVER_CYC) begin m_mode = 1; entered = 1'b1; end
      end
    end else if (m_mode == 1) begin
      if (v != 0) model_fault(v);
      else for (int i = 0; i < 4; i++) m_lamp[i] = m_cur[i];
    end else begin
      m_fcnt++;
      if (m_fcnt == FLASH_HALF) begin m_fcnt = 0; m_on = 1 - m_on; end
      for (int i = 0; i < 4; i++) m_lamp[i] = (m_on != 0) ? 4 : 0;
      if (clr && v_lo == 0) begin
        m_mode = 0; m_fault = 0; m_code = 0; m_hold = 0;
        for (int i = 0; i < 4; i++) m_lamp[i] = 4;
      end
    end
    m_same_run = (unchanged && !entered) ? m_same_run + 1 : 0;
    m_ya = (m_cur[0] == 2) ? ((m_ya < 7) ? m_ya + 1 : 7) : 0;
    m_yb = (m_cur[1] == 2) ? ((m_yb < 7) ? m_yb + 1 : 7) : 0;
    for (int i = 0; i < 4; i++) m_prev[i] = m_cur[i];
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic [11:0] p, input logic clr);
    logic [15:0] exp;
    l1 = p[11:9]; l2 = p[8:6]; l3 = p[5:3]; l4 = p[2:0]; fclr = clr;
    @(posedge clk);
    m_cur[0] = int'(l1); m_cur[1] = int'(l2); m_cur[2] = int'(l3); m_cur[3] = int'(l4);
    model_step(clr);
    #1;
    exp = {3'(m_lamp[0]), 3'(m_lamp[1]), 3'(m_lamp[2]), 3'(m_lamp[3]), 1'(m_fault), 3'(m_code)};
    chk("model", {lamps_w, fault, fault_code}, exp);
  endtask

  task automatic clear_recover();
    step(ALLR, 1'b1);
    chk("clear_fault", fault, 1'b0);
    repeat (RECOVER_CYC + 1) step(AGRN, 1'b0);
    chk("recover_pass", lamps_w, AGRN);
  endtask

  function automatic logic [11:0] nominal(input int k);
    int p;
    p = k % 30;
    if (p < 11) return AGRN;
    if (p < 15) return AYEL;
    if (p < 26) return BGRN;
    return BYEL;
  endfunction

  typedef struct {
    logic [11:0] in;
    logic        clr;
    logic [11:0] lamps;
    logic        flt;
    logic [2:0]  code;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [11:0] in, input logic clr, input logic [11:0] lamps,
                     input logic flt, input logic [2:0] code);
    vec_t v;
    v.in = in; v.clr = clr; v.lamps = lamps; v.flt = flt; v.code = code;
    tbl.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [11:0] p, pat;
    int ph, rem, idx;

    // conflict, flashing, blocked clear, clean clear, recovery, short yellow
    add(CONF, 1'b0, ALLR, 1'b1, 3'd2);
    for (int j = 1; j <= 11; j++) add(CONF, 1'b0, ((j / 4) % 2 == 0) ? ALLR : OFF, 1'b1, 3'd2);
    add(CONF, 1'b1, OFF, 1'b1, 3'd2);
    add(ALLR, 1'b1, ALLR, 1'b0, 3'd0);
    for (int j = 0; j < RECOVER_CYC; j++) add(AGRN, 1'b0, ALLR, 1'b0, 3'd0);
    add(AGRN, 1'b0, AGRN, 1'b0, 3'd0);
    add(AYEL, 1'b0, AYEL, 1'b0, 3'd0);
    add(AYEL, 1'b0, AYEL, 1'b0, 3'd0);
    add(ALLR, 1'b0, ALLR, 1'b1, 3'd5);

    rst = 1'b1; fclr = 1'b0;
    l1 = RED; l2 = RED; l3 = RED; l4 = RED;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lamps", lamps_w, ALLR);
    chk("reset_fault", fault, 1'b0);
    chk("reset_code", fault_code, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // nominal controller, three full rounds
    for (int k = 0; k < 90; k++) begin
      pat = nominal(k);
      step(pat, 1'b0);
      if (k < RECOVER_CYC) chk("nominal_red", lamps_w, ALLR);
      else                 chk("nominal_pass", lamps_w, pat);
      chk("nominal_fault", fault, 1'b0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in, tbl[i].clr);
      chk($sformatf("tbl[%0d]", i), {lamps_w, fault, fault_code},
          {tbl[i].lamps, tbl[i].flt, tbl[i].code});
    end

    // GREEN straight to RED
    clear_recover();
    step(ALLR, 1'b0);
    chk("seq_fault", fault, 1'b1);
    chk("seq_code", fault_code, 3'd4);

    // unchanged inputs: the 64th unchanged sample trips
    clear_recover();
    step(AYEL, 1'b0);
    for (int k = 1; k <= MAX_STABLE; k++) begin
      step(AYEL, 1'b0);
      if (k == MAX_STABLE - 1) chk("stuck_before", fault, 1'b0);
      if (k == MAX_STABLE) begin
        chk("stuck_fault", fault, 1'b1);
        chk("stuck_code", fault_code, 3'd6);
      end
    end

    // illegal code beats a simultaneous conflict
    clear_recover();
    p = {GRN, GRN, GRN, 3'b011};
    step(p, 1'b0);
    chk("prio_fault", fault, 1'b1);
    chk("prio_code", fault_code, 3'd1);
    repeat (6) step(p, 1'b0);
    chk("flash_off", lamps_w, OFF);

    // asynchronous reset in the middle of the flash
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_lamps", lamps_w, ALLR);
    chk("midrst_fault", fault, 1'b0);
    chk("midrst_code", fault_code, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // random controller traffic with occasional corruption and clears
    ph = 0;
    rem = $urandom_range(1, 12);
    repeat (3000) begin
      case (ph)
        0: p = AGRN;
        1: p = AYEL;
        2: p = BGRN;
        default: p = BYEL;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 3);
        p[idx*3 +: 3] = 3'($urandom_range(0, 7));
      end
      step(p, $urandom_range(0, 3) == 0);
      rem--;
      if (rem == 0) begin
        ph = (ph + 1) % 4;
        if (ph % 2 == 1) rem = $urandom_range(1, 5);
        else if ($urandom_range(0, 9) == 0) rem = $urandom_range(60, 70);
        else rem = $urandom_range(1, 12);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
